// File: rtl/telemetre_ultrason_if.sv
// Sensor pins and display/LED outputs of the ultrasonic ranging engine.
// master = ranging engine, slave = sensor/display side.
interface telemetre_ultrason_if #(
  parameter int DIST_W = 10
);
  logic              Echo;
  logic              Trig;
  logic [DIST_W-1:0] Distance;
  logic [3:0]        Centaine;
  logic [3:0]        Dizaine;
  logic [3:0]        Unite;
  logic              Valid;
  logic              Timeout;
  logic              CmdLED;

  modport master (
    input  Echo,
    output Trig, Distance, Centaine, Dizaine, Unite, Valid, Timeout, CmdLED
  );

  modport slave (
    output Echo,
    input  Trig, Distance, Centaine, Dizaine, Unite, Valid, Timeout, CmdLED
  );
endinterface

// File: rtl/telemetre_ultrason.sv
// Ultrasonic ranging engine: trigger, echo-width measurement, averaging, BCD and proximity LED.
// Define TELEMETRE_AVG_EN to build the 2**AVG_LOG2-deep averaging buffer; otherwise raw samples pass through.
module telemetre_ultrason #(
  parameter int DIST_W     = 10,
  parameter int TICK_DIV   = 2900,
  parameter int PERIOD_CYC = 2500000,
  parameter int TRIG_CYC   = 500,
  parameter int ECHO_WAIT  = 1500000,
  parameter int DIST_MAX   = 400,
  parameter int AVG_LOG2   = 2,
  parameter int THRESH     = 20,
  parameter int HYST       = 2
) (
  input logic                  Clk,
  input logic                  Rst_n,
  telemetre_ultrason_if.master bus
);

  localparam int CNT_MAX = (ECHO_WAIT > TRIG_CYC) ? ((ECHO_WAIT > DIST_W) ? ECHO_WAIT : DIST_W)
                                                  : ((TRIG_CYC > DIST_W) ? TRIG_CYC : DIST_W);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int PER_W = $clog2(PERIOD_CYC + 1);
  localparam int PRE_W = $clog2(TICK_DIV + 1);

  localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(ECHO_WAIT - 1);
  localparam logic [CNT_W-1:0]  BCD_LAST  = CNT_W'(DIST_W - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYC - 1);
  localparam logic [PRE_W-1:0]  TICK_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DIST_W-1:0] SAMP_LAST = DIST_W'(DIST_MAX - 1);
  localparam logic [DIST_W-1:0] LED_ON    = DIST_W'(THRESH);
  localparam logic [DIST_W-1:0] LED_OFF   = DIST_W'(THRESH + HYST);

  if (DIST_W > 10) begin : g_dist_w_check
    $error("DIST_W must not exceed 10: only three BCD digits are produced");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_ECHO, S_MEASURE, S_AVG, S_BCD, S_DONE
  } state_t;

  state_t            state, next_state;
  logic              to_flag;
  logic [CNT_W-1:0]  step_cnt;
  logic [PER_W-1:0]  per_cnt;
  logic              start_req;
  logic              echo_s1, echo_s2, echo_s3, echo_rise;
  logic [PRE_W-1:0]  prescale;
  logic              tick;
  logic [DIST_W-1:0] sample;
  logic [DIST_W-1:0] avg_result;
  logic [DIST_W-1:0] res_q;
  logic [DIST_W-1:0] bin_sh;
  logic [11:0]       bcd_sh, bcd_adj, bcd_next;
  logic              trig_q, valid_q, timeout_q, led_q;
  logic [DIST_W-1:0] dist_q;
  logic [3:0]        cen_q, diz_q, uni_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_s3 <= 1'b0;
    end else begin
      echo_s1 <= bus.Echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
    end
  end

  // echo_s3 is the level the FSM measures; the rise is caught one stage earlier so it lines up.
  assign echo_rise = echo_s2 & ~echo_s3;
  assign start_req = (per_cnt == PER_LAST);
  assign tick      = (prescale == TICK_LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      per_cnt  <= '0;
      state    <= S_IDLE;
      step_cnt <= '0;
    end else begin
      per_cnt  <= start_req ? '0 : per_cnt + 1'b1;
      state    <= next_state;
      step_cnt <= (next_state != state) ? '0 : step_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    to_flag    = 1'b0;
    case (state)
      S_IDLE:      if (start_req) next_state = S_TRIG;
      S_TRIG:      if (step_cnt == TRIG_LAST) next_state = S_WAIT_ECHO;
      S_WAIT_ECHO: begin
        if (echo_rise) begin
          next_state = S_MEASURE;
        end else if (step_cnt == WAIT_LAST) begin
          next_state = S_DONE;
          to_flag    = 1'b1;
        end
      end
      S_MEASURE: begin
        if (!echo_s3) begin
          next_state = S_AVG;
        end else if (tick && sample == SAMP_LAST) begin
          next_state = S_DONE;
          to_flag    = 1'b1;
        end
      end
      S_AVG:       next_state = S_BCD;
      S_BCD:       if (step_cnt == BCD_LAST) next_state = S_DONE;
      S_DONE:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

`ifdef TELEMETRE_AVG_EN
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W = DIST_W + AVG_LOG2;

  logic [DIST_W-1:0] avg_buf [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [SUM_W-1:0]  avg_sum, sum_next;
  logic              buf_full;

  // The first sample after reset fills every slot so the average starts at that sample.
  always_comb begin
    if (buf_full) sum_next = avg_sum - SUM_W'(avg_buf[wr_ptr]) + SUM_W'(sample);
    else          sum_next = SUM_W'(sample) << AVG_LOG2;
    avg_result = DIST_W'(sum_next >> AVG_LOG2);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr   <= '0;
      avg_sum  <= '0;
      buf_full <= 1'b0;
    end else if (state == S_AVG) begin
      avg_sum  <= sum_next;
      buf_full <= 1'b1;
      if (buf_full) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (state == S_AVG) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!buf_full || PTR_W'(i) == wr_ptr) avg_buf[i] <= sample;
      end
    end
  end
`else
  if (AVG_LOG2 < 0) begin : g_avg_log2_check
    $error("AVG_LOG2 must not be negative");
  end

  assign avg_result = sample;
`endif

  always_comb begin
    bcd_adj = bcd_sh;
    for (int d = 0; d < 3; d++) begin
      if (bcd_sh[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sh[4*d +: 4] + 4'd3;
    end
  end

  assign bcd_next = {bcd_adj[10:0], bin_sh[DIST_W-1]};

  // bcd_adj[11] is rotated into the spent end of bin_sh; it never reaches the MSB within DIST_W shifts.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prescale  <= '0;
      sample    <= '0;
      res_q     <= '0;
      bin_sh    <= '0;
      bcd_sh    <= '0;
      trig_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      led_q     <= 1'b0;
      dist_q    <= '0;
      cen_q     <= '0;
      diz_q     <= '0;
      uni_q     <= '0;
    end else begin
      trig_q  <= (next_state == S_TRIG);
      valid_q <= (next_state == S_DONE);

      if (state == S_WAIT_ECHO) begin
        prescale <= '0;
        sample   <= '0;
      end else if (state == S_MEASURE && echo_s3) begin
        if (tick) begin
          prescale <= '0;
          sample   <= sample + 1'b1;
        end else begin
          prescale <= prescale + 1'b1;
        end
      end

      if (state == S_AVG) begin
        res_q  <= avg_result;
        bin_sh <= avg_result;
        bcd_sh <= '0;
      end else if (state == S_BCD) begin
        bcd_sh <= bcd_next;
        bin_sh <= {bin_sh[DIST_W-2:0], bcd_adj[11]};
      end

      if (next_state == S_DONE) begin
        if (to_flag) begin
          timeout_q <= 1'b1;
        end else begin
          timeout_q <= 1'b0;
          dist_q    <= res_q;
          {cen_q, diz_q, uni_q} <= bcd_next;
          if (res_q < LED_ON)        led_q <= 1'b1;
          else if (res_q >= LED_OFF) led_q <= 1'b0;
        end
      end
    end
  end

  assign bus.Trig     = trig_q;
  assign bus.Valid    = valid_q;
  assign bus.Timeout  = timeout_q;
  assign bus.CmdLED   = led_q;
  assign bus.Distance = dist_q;
  assign bus.Centaine = cen_q;
  assign bus.Dizaine  = diz_q;
  assign bus.Unite    = uni_q;

endmodule

// File: tb/tb_telemetre_ultrason.sv
// Directed bench for telemetre_ultrason: a sample-history model checked every cycle,
// plus literal checkpoints for each scenario (averaged or raw, following TELEMETRE_AVG_EN).
module tb_telemetre_ultrason;

  localparam int DIST_W     = 10;
  localparam int TICK_DIV   = 4;
  localparam int PERIOD_CYC = 2000;
  localparam int TRIG_CYC   = 5;
  localparam int ECHO_WAIT  = 100;
  localparam int DIST_MAX   = 300;
  localparam int AVG_LOG2   = 2;
  localparam int THRESH     = 20;
  localparam int HYST       = 2;

  logic clk = 1'b0;
  logic rstN;
  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;
  int   validCount = 0;
  int   pending[$];
  int   history[$];
  int   mDist = 0, mCen = 0, mDiz = 0, mUni = 0, mTo = 0, mLed = 0;

  telemetre_ultrason_if #(.DIST_W(DIST_W)) bus ();

  telemetre_ultrason #(
    .DIST_W(DIST_W), .TICK_DIV(TICK_DIV), .PERIOD_CYC(PERIOD_CYC), .TRIG_CYC(TRIG_CYC),
    .ECHO_WAIT(ECHO_WAIT), .DIST_MAX(DIST_MAX), .AVG_LOG2(AVG_LOG2), .THRESH(THRESH), .HYST(HYST)
  ) dut (
    .Clk  (clk),
    .Rst_n(rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; trigger pulses occupy the first TRIG_CYC cycles of each period.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int packOut(input int d, input int c, input int z, input int u, input int t, input int l);
    return (d << 14) | (c << 10) | (z << 6) | (u << 2) | (t << 1) | l;
  endfunction

  // Model: echo-high cycles -> sample -> (average of last 2**AVG_LOG2 samples) -> digits and LED.
  task automatic modelApply(input int highCycles);
    int s;
    int sum;
    s = highCycles / TICK_DIV;
    if (highCycles < 0 || s >= DIST_MAX) begin
      mTo = 1;
    end else begin
      mTo = 0;
`ifdef TELEMETRE_AVG_EN
      if (history.size() == 0) begin
        repeat (1 << AVG_LOG2) history.push_back(s);
      end else begin
        history.push_back(s);
        void'(history.pop_front());
      end
      sum = 0;
      foreach (history[i]) sum += history[i];
      mDist = sum / (1 << AVG_LOG2);
`else
      sum   = s;
      mDist = sum;
`endif
      mCen = mDist / 100;
      mDiz = (mDist / 10) % 10;
      mUni = mDist % 10;
      if (mDist < THRESH)             mLed = 1;
      else if (mDist >= THRESH + HYST) mLed = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rstN) begin
      pending.delete();
      history.delete();
      mDist = 0; mCen = 0; mDiz = 0; mUni = 0; mTo = 0; mLed = 0;
    end else begin
      checkOutput("trig_cycle", bus.Trig,
                  (cyc >= PERIOD_CYC && (cyc % PERIOD_CYC) < TRIG_CYC) ? 1 : 0);
      if (bus.Valid) begin
        validCount++;
        checkOutput("pending_on_valid", (pending.size() > 0) ? 1 : 0, 1);
        if (pending.size() > 0) modelApply(pending.pop_front());
        checkOutput("valid_distance", bus.Distance, mDist);
        checkOutput("valid_centaine", bus.Centaine, mCen);
        checkOutput("valid_dizaine",  bus.Dizaine,  mDiz);
        checkOutput("valid_unite",    bus.Unite,    mUni);
        checkOutput("valid_timeout",  bus.Timeout,  mTo);
        checkOutput("valid_cmdled",   bus.CmdLED,   mLed);
      end else begin
        checkOutput("hold_outputs",
                    packOut(bus.Distance, bus.Centaine, bus.Dizaine, bus.Unite, bus.Timeout, bus.CmdLED),
                    packOut(mDist, mCen, mDiz, mUni, mTo, mLed));
      end
    end
  end

  task automatic waitValid(input int startCount, input string name);
    int n;
    n = 0;
    while (validCount == startCount && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_valid_count"}, validCount - startCount, 1);
  endtask

  task automatic waitTrigFall(input string name);
    int n;
    n = 0;
    while (bus.Trig !== 1'b1 && n < 2500) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_trig_rise"}, bus.Trig, 1);
    n = 0;
    while (bus.Trig !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_trig_fall"}, bus.Trig, 0);
  endtask

  // highCycles < 0 means no echo at all.
  task automatic applyStimulus(input int highCycles, input string name);
    int start;
    waitTrigFall(name);
    start = validCount;
    if (highCycles < 0) begin
      pending.push_back(-1);
      waitValid(start, name);
    end else begin
      repeat (3) @(negedge clk);
      bus.Echo = 1'b1;
      if (highCycles / TICK_DIV >= DIST_MAX) pending.push_back(highCycles);
      repeat (highCycles) @(negedge clk);
      if (highCycles / TICK_DIV >= DIST_MAX)
        checkOutput({name, "_valid_before_fall"}, validCount - start, 1);
      bus.Echo = 1'b0;
      if (highCycles / TICK_DIV < DIST_MAX) begin
        pending.push_back(highCycles);
        waitValid(start, name);
      end
    end
  endtask

  task automatic checkLiteral(input string name, input int d, input int c, input int z,
                              input int u, input int t, input int l);
    checkOutput({name, "_distance"}, bus.Distance, d);
    checkOutput({name, "_centaine"}, bus.Centaine, c);
    checkOutput({name, "_dizaine"},  bus.Dizaine,  z);
    checkOutput({name, "_unite"},    bus.Unite,    u);
    checkOutput({name, "_timeout"},  bus.Timeout,  t);
    checkOutput({name, "_cmdled"},   bus.CmdLED,   l);
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_trig"},  bus.Trig,  0);
    checkOutput({name, "_valid"}, bus.Valid, 0);
    checkLiteral(name, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    rstN     = 1'b0;
    bus.Echo = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    #1 rstN = 1'b1;

    applyStimulus(-1, "noecho");
    checkLiteral("noecho", 0, 0, 0, 0, 1, 0);

    applyStimulus(500, "m125");
    checkLiteral("m125", 125, 1, 2, 5, 0, 0);

    applyStimulus(100, "m25");
`ifdef TELEMETRE_AVG_EN
    checkLiteral("m25", 100, 1, 0, 0, 0, 0);
`else
    checkLiteral("m25", 25, 0, 2, 5, 0, 0);
`endif

    applyStimulus(1300, "sat");
`ifdef TELEMETRE_AVG_EN
    checkLiteral("sat", 100, 1, 0, 0, 1, 0);
`else
    checkLiteral("sat", 25, 0, 2, 5, 1, 0);
`endif

    applyStimulus(78, "s19");
`ifdef TELEMETRE_AVG_EN
    checkLiteral("s19", 73, 0, 7, 3, 0, 0);
`else
    checkLiteral("s19", 19, 0, 1, 9, 0, 1);
`endif
    applyStimulus(86, "s21");
`ifdef TELEMETRE_AVG_EN
    checkLiteral("s21", 47, 0, 4, 7, 0, 0);
`else
    checkLiteral("s21", 21, 0, 2, 1, 0, 1);
`endif
    applyStimulus(90, "s22");
`ifdef TELEMETRE_AVG_EN
    checkLiteral("s22", 21, 0, 2, 1, 0, 0);
`else
    checkLiteral("s22", 22, 0, 2, 2, 0, 0);
`endif

    waitTrigFall("rst_measure");
    repeat (3) @(negedge clk);
    bus.Echo = 1'b1;
    repeat (40) @(negedge clk);
    #2 rstN = 1'b0;
    #1 checkReset("rst_measure");
    bus.Echo = 1'b0;
    repeat (3) @(negedge clk);
    #1 rstN = 1'b1;

    applyStimulus(200, "after_rst");
    checkLiteral("after_rst", 50, 0, 5, 0, 0, 0);

    n = 0;
    while (bus.Trig !== 1'b1 && n < 2500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_trig_before", bus.Trig, 1);
    #2 rstN = 1'b0;
    #1 checkOutput("rst_trig_async", bus.Trig, 0);
    repeat (2) @(negedge clk);
    #1 rstN = 1'b1;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish by time %0t, expected finish", $time);
    $fatal(1, "[TB] time limit reached");
  end

endmodule
